// File: rtl/halflife_input_conditioner_if.sv
// Panel-side bundle for the half-life input conditioner: raw buttons in,
// clean command strobes out, plus per-channel FSM state for observation.
//
// Handshake semantics: up, down and load are one-cycle strobes with no
// backpressure. A strobe is a command the consumer must take in the cycle it
// is high, and at most one of the three is high in any cycle. load_data is
// valid while load is high and holds its value until the next load.
//
// up_state/down_state encoding: 0 = IDLE, 1 = HOLD, 2 = REPEAT.
interface halflife_input_conditioner_if;
  logic       up_btn;
  logic       down_btn;
  logic       load_btn;
  logic [3:0] load_val;
  logic       up;
  logic       down;
  logic       load;
  logic [3:0] load_data;
  logic [1:0] up_state;
  logic [1:0] down_state;

  modport master (
    output up_btn, down_btn, load_btn, load_val,
    input  up, down, load, load_data, up_state, down_state
  );

  modport slave (
    input  up_btn, down_btn, load_btn, load_val,
    output up, down, load, load_data, up_state, down_state
  );
endinterface

// File: rtl/halflife_input_conditioner.sv
// Input conditioner for the half-life timer core: synchronizes and debounces
// the panel buttons, auto-repeats up/down while held, resolves up/down
// conflicts and gives load priority, so the core sees one command per cycle.
module halflife_input_conditioner #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int RATE_CYCLES = 8
) (
  input logic                        clk,
  input logic                        reset,
  halflife_input_conditioner_if.slave bus
);

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LOAD = 2;

  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int TMAX = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } ch_state_t;

  logic [2:0]    raw;
  logic [2:0]    btn_s1;
  logic [2:0]    btn_s2;
  logic [3:0]    val_s1;
  logic [3:0]    val_s2;

  logic [2:0]    stable;
  logic [2:0]    stable_nx;
  logic [DW-1:0] db_cnt    [3];
  logic [DW-1:0] db_cnt_nx [3];

  ch_state_t     state     [2];
  ch_state_t     state_nx  [2];
  logic [TW-1:0] timer     [2];
  logic [TW-1:0] timer_nx  [2];
  logic [1:0]    strobe;
  logic          conflict;
  logic          load_rise;

  assign raw = {bus.load_btn, bus.down_btn, bus.up_btn};

  // Two-flop synchronizers for every raw panel input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      val_s1 <= '0;
      val_s2 <= '0;
    end else begin
      btn_s1 <= raw;
      btn_s2 <= btn_s1;
      val_s1 <= bus.load_val;
      val_s2 <= val_s1;
    end
  end

  // Debounce: stable flips once sync has disagreed for DB_CYCLES cycles.
  always_comb begin
    stable_nx = stable;
    for (int i = 0; i < 3; i++) begin
      db_cnt_nx[i] = '0;
      if (btn_s2[i] != stable[i]) begin
        if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          stable_nx[i] = ~stable[i];
        end else begin
          db_cnt_nx[i] = db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nx;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= db_cnt_nx[i];
      end
    end
  end

  // Both up and down held means neither is trusted: park both in IDLE.
  assign conflict  = stable_nx[BTN_UP] & stable_nx[BTN_DOWN];
  assign load_rise = stable_nx[BTN_LOAD] & ~stable[BTN_LOAD];

  // Up/down auto-repeat FSMs: next state, timer and strobe per channel.
  always_comb begin
    strobe = '0;
    for (int ch = 0; ch < 2; ch++) begin
      state_nx[ch] = state[ch];
      timer_nx[ch] = timer[ch];
      if (!stable_nx[ch] || conflict) begin
        state_nx[ch] = IDLE;
        timer_nx[ch] = '0;
      end else begin
        case (state[ch])
          IDLE: begin
            // Only a genuine rise starts a sequence; a button left held
            // after a conflict stays silent.
            if (!stable[ch]) begin
              strobe[ch]   = 1'b1;
              state_nx[ch] = HOLD;
              timer_nx[ch] = '0;
            end
          end
          HOLD: begin
            if (timer[ch] == TW'(HOLD_CYCLES - 1)) begin
              strobe[ch]   = 1'b1;
              state_nx[ch] = REPEAT;
              timer_nx[ch] = '0;
            end else begin
              timer_nx[ch] = timer[ch] + 1'b1;
            end
          end
          REPEAT: begin
            if (timer[ch] == TW'(RATE_CYCLES - 1)) begin
              strobe[ch]   = 1'b1;
              timer_nx[ch] = '0;
            end else begin
              timer_nx[ch] = timer[ch] + 1'b1;
            end
          end
          default: begin
            state_nx[ch] = IDLE;
            timer_nx[ch] = '0;
          end
        endcase
      end
    end
  end

  // FSM state and timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        state[ch] <= IDLE;
        timer[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state[ch] <= state_nx[ch];
        timer[ch] <= timer_nx[ch];
      end
    end
  end

  // Registered outputs; load wins the cycle but FSMs keep advancing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.up        <= 1'b0;
      bus.down      <= 1'b0;
      bus.load      <= 1'b0;
      bus.load_data <= '0;
    end else begin
      bus.up   <= strobe[BTN_UP]   & ~load_rise;
      bus.down <= strobe[BTN_DOWN] & ~load_rise;
      bus.load <= load_rise;
      if (load_rise) begin
        bus.load_data <= val_s2;
      end
    end
  end

  assign bus.up_state   = state[BTN_UP];
  assign bus.down_state = state[BTN_DOWN];

endmodule

// File: tb/tb_halflife_input_conditioner.sv
// Bench for halflife_input_conditioner: directed panel scenarios plus random
// button activity, checked through an expected-strobe queue fed by a
// reference model of the conditioning rules.
module tb_halflife_input_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 16;
  localparam int RATE = 8;
  localparam int W    = 23;  // {cycle[15:0], up, down, load, load_data[3:0]}

  logic clk   = 1'b0;
  logic reset = 1'b1;

  halflife_input_conditioner_if ifc ();

  halflife_input_conditioner #(
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD),
    .RATE_CYCLES(RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int fails    = 0;
  int up_cnt   = 0;
  int down_cnt = 0;
  int load_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  cyc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, need %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    up_cnt   = 0;
    down_cnt = 0;
    load_cnt = 0;
  endtask

  // ---------------- reference model ----------------
  // Each button's debounced level changes after DB consecutive synchronized
  // samples disagree with it. A press sequence is tracked by its age in
  // cycles since the initial strobe: strobes fall at age 0, HOLD, and every
  // RATE after that. Any release or up+down overlap ends the sequence.
  logic [2:0] m_s1, m_s2, m_st;
  logic [3:0] m_v1, m_v2, m_ld;
  int         m_run [3];
  int         m_age [2];

  always @(posedge clk) begin
    logic [2:0] ns;
    logic [1:0] sb;
    logic       conf, lr;
    cyc = cyc + 16'd1;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_st = '0;
      m_v1 = '0; m_v2 = '0; m_ld = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_age[0] = -1;
      m_age[1] = -1;
    end else begin
      ns = m_st;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] >= DB) begin
            ns[i]    = ~m_st[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      conf = ns[0] & ns[1];
      sb   = '0;
      for (int ch = 0; ch < 2; ch++) begin
        if (!ns[ch] || conf) begin
          m_age[ch] = -1;
        end else if (!m_st[ch]) begin
          m_age[ch] = 0;
          sb[ch]    = 1'b1;
        end else if (m_age[ch] >= 0) begin
          m_age[ch]++;
          if (m_age[ch] == HOLD || (m_age[ch] > HOLD && (m_age[ch] - HOLD) % RATE == 0))
            sb[ch] = 1'b1;
        end
      end
      lr = ns[2] & ~m_st[2];
      if (lr) m_ld = m_v2;
      if (lr || sb != 2'b00)
        exp_q.push_back({cyc, sb[0] & ~lr, sb[1] & ~lr, lr, m_ld});
      m_st = ns;
      m_s2 = m_s1;
      m_s1 = {ifc.load_btn, ifc.down_btn, ifc.up_btn};
      m_v2 = m_v1;
      m_v1 = ifc.load_val;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, want, head;
    if (!reset) begin
      // Anything expected at an earlier cycle that is still queued was missed.
      while (exp_q.size() != 0) begin
        head = exp_q[0];
        if (head[W-1 -: 16] >= cyc) break;
        void'(exp_q.pop_front());
        checks++;
        fails++;
        $display("FAIL missed_strobe: got nothing, need %h", head);
      end
      if (ifc.up || ifc.down || ifc.load) begin
        if (ifc.up)   up_cnt++;
        if (ifc.down) down_cnt++;
        if (ifc.load) load_cnt++;
        got = {cyc, ifc.up, ifc.down, ifc.load, ifc.load_data};
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got %h, need none", got);
        end else begin
          want = exp_q.pop_front();
          check("strobe", 32'(got), 32'(want));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    int hl [3];
    bit lvl;
    ifc.up_btn   = 1'b0;
    ifc.down_btn = 1'b0;
    ifc.load_btn = 1'b0;
    ifc.load_val = 4'h0;
    reset        = 1'b1;
    step(3);
    check("reset_outputs", 32'({ifc.up, ifc.down, ifc.load, ifc.load_data}), 32'h0);
    check("reset_up_state", 32'(ifc.up_state), 32'h0);
    reset = 1'b0;
    step(2);

    // Glitch of 3 cycles is rejected.
    clear_counts();
    ifc.up_btn = 1'b1;
    step(3);
    ifc.up_btn = 1'b0;
    step(12);
    check("glitch_up_count", 32'(up_cnt), 32'd0);
    check("glitch_up_state", 32'(ifc.up_state), 32'h0);

    // Hold: strobes at edges 5, 21, 29, 37; released before edge 45 repeat.
    clear_counts();
    ifc.up_btn = 1'b1;
    step(40);
    ifc.up_btn = 1'b0;
    step(20);
    check("hold_up_count", 32'(up_cnt), 32'd4);

    // Conflict: down joins at edge 10, both silent; up silent after down goes.
    clear_counts();
    ifc.up_btn = 1'b1;
    step(10);
    ifc.down_btn = 1'b1;
    step(30);
    check("conflict_up_count", 32'(up_cnt), 32'd1);
    check("conflict_down_count", 32'(down_cnt), 32'd0);
    ifc.down_btn = 1'b0;
    step(20);
    check("conflict_survivor_silent", 32'(up_cnt), 32'd1);
    ifc.up_btn = 1'b0;
    step(12);
    ifc.up_btn = 1'b1;
    step(10);
    ifc.up_btn = 1'b0;
    step(12);
    check("conflict_repress", 32'(up_cnt), 32'd2);

    // Load captures the synchronized value and holds it.
    clear_counts();
    ifc.load_val = 4'hA;
    step(4);
    ifc.load_btn = 1'b1;
    step(8);
    ifc.load_btn = 1'b0;
    step(8);
    check("load_count", 32'(load_cnt), 32'd1);
    check("load_data", 32'(ifc.load_data), 32'hA);
    ifc.load_val = 4'h3;
    step(10);
    check("load_data_held", 32'(ifc.load_data), 32'hA);
    check("load_no_extra", 32'(load_cnt), 32'd1);

    // Priority: load and up rise together; up FSM still enters HOLD.
    clear_counts();
    ifc.up_btn   = 1'b1;
    ifc.load_btn = 1'b1;
    step(6);
    check("prio_load_count", 32'(load_cnt), 32'd1);
    check("prio_up_suppressed", 32'(up_cnt), 32'd0);
    check("prio_up_state_hold", 32'(ifc.up_state), 32'd1);
    ifc.load_btn = 1'b0;
    step(14);
    ifc.up_btn = 1'b0;
    step(12);
    check("prio_hold_strobe", 32'(up_cnt), 32'd1);

    // Reset in REPEAT, released with up still held: fresh sequence.
    clear_counts();
    ifc.up_btn = 1'b1;
    step(25);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ifc.up) begin
        found = 1'b1;
        break;
      end
    end
    check("repeat_strobe_seen", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_outputs", 32'({ifc.up, ifc.down, ifc.load, ifc.load_data}), 32'h0);
    exp_q.delete();
    step(3);
    check("midreset_up_state", 32'(ifc.up_state), 32'h0);
    clear_counts();
    reset = 1'b0;
    step(30);
    ifc.up_btn = 1'b0;
    step(12);
    check("post_reset_up_count", 32'(up_cnt), 32'd3);

    // Random button activity, including sub-debounce glitches.
    for (int i = 0; i < 3; i++) hl[i] = 0;
    repeat (800) begin
      for (int i = 0; i < 3; i++) begin
        if (hl[i] == 0) begin
          lvl   = 1'($urandom_range(0, 1));
          hl[i] = $urandom_range(1, 30);
          case (i)
            0:       ifc.up_btn   = lvl;
            1:       ifc.down_btn = lvl;
            default: ifc.load_btn = lvl;
          endcase
        end
        hl[i]--;
      end
      if ($urandom_range(0, 7) == 0) ifc.load_val = 4'($urandom_range(0, 15));
      step(1);
    end
    ifc.up_btn   = 1'b0;
    ifc.down_btn = 1'b0;
    ifc.load_btn = 1'b0;
    step(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
